// File: rtl/alu_div_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master drives start/N/D; the divider (slave) returns Q/R and status.
interface alu_div_if;
    logic       start;
    logic [7:0] N;
    logic [3:0] D;
    logic [7:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       dz;
    logic       ovf;

    modport master (
        output start, N, D,
        input  Q, R, busy, done, dz, ovf
    );

    modport slave (
        input  start, N, D,
        output Q, R, busy, done, dz, ovf
    );
endinterface

// File: rtl/alu_div.sv
// Sequential signed divider (8-bit dividend / 4-bit divisor), restoring
// algorithm, one quotient bit per clock; truncating quotient, remainder signed like N.
module alu_div (
    input  logic       clk,
    input  logic       ar,
    alu_div_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // control / architecturally visible state (reset)
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_dz;
    logic       r_ovf;
    logic       r_dzp;
    logic [7:0] r_Q;
    logic [3:0] r_R;

    // datapath state (no reset; always loaded before use)
    logic [7:0] r_q;
    logic [3:0] r_rem;
    logic [3:0] r_dmag;
    logic       r_qneg;
    logic       r_rneg;

    logic signed [7:0] w_n;
    logic signed [3:0] w_d;
    logic       w_load;
    logic       w_dzarm;
    logic       w_dzfire;
    logic       w_step;
    logic       w_fix;
    logic [4:0] w_sh;
    logic       w_ge;

    function automatic logic [7:0] abs8(input logic signed [7:0] v);
        logic [7:0] u;
        u = v;
        return v[7] ? (~u + 8'd1) : u;
    endfunction

    function automatic logic [3:0] abs4(input logic signed [3:0] v);
        logic [3:0] u;
        u = v;
        return v[3] ? (~u + 4'd1) : u;
    endfunction

    function automatic logic [7:0] neg8(input logic [7:0] m);
        return ~m + 8'd1;
    endfunction

    function automatic logic [3:0] neg4(input logic [3:0] m);
        return ~m + 4'd1;
    endfunction

    assign w_n  = bus.N;
    assign w_d  = bus.D;
    assign w_sh = {r_rem, r_q[7]};
    assign w_ge = (w_sh >= {1'b0, r_dmag});

    // A divide-by-zero is armed on the start edge and reported one edge later.
    always_comb begin
        w_load   = 1'b0;
        w_dzarm  = 1'b0;
        w_dzfire = 1'b0;
        w_step   = 1'b0;
        w_fix    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dzfire = r_dzp;
                w_load   = !r_dzp && bus.start && (w_d != 4'sd0);
                w_dzarm  = !r_dzp && bus.start && (w_d == 4'sd0);
            end
            S_CALC:  w_step = 1'b1;
            S_FIX:   w_fix  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == 4'd7) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!ar) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!ar) begin
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
            r_dzp  <= 1'b0;
            r_Q    <= 8'd0;
            r_R    <= 4'd0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_cnt  <= 4'd0;
                r_busy <= 1'b1;
            end
            if (w_dzarm) r_dzp <= 1'b1;
            if (w_dzfire) begin
                r_dzp  <= 1'b0;
                r_Q    <= 8'd0;
                r_R    <= 4'd0;
                r_dz   <= 1'b1;
                r_ovf  <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_step) r_cnt <= r_cnt + 4'd1;
            // Only -128/-1 leaves a positive magnitude of 128; Q keeps the 8'h80 pattern.
            if (w_fix) begin
                r_Q    <= r_qneg ? neg8(r_q) : r_q;
                r_R    <= r_rneg ? neg4(r_rem) : r_rem;
                r_dz   <= 1'b0;
                r_ovf  <= (r_q == 8'h80) && !r_qneg;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_q    <= abs8(w_n);
            r_dmag <= abs4(w_d);
            r_rem  <= 4'd0;
            r_qneg <= w_n[7] ^ w_d[3];
            r_rneg <= w_n[7];
        end else if (w_step) begin
            // Post-subtract remainder is below dmag (<=8), so 4 bits suffice.
            if (w_ge) begin
                r_rem <= 4'(w_sh - {1'b0, r_dmag});
                r_q   <= {r_q[6:0], 1'b1};
            end else begin
                r_rem <= w_sh[3:0];
                r_q   <= {r_q[6:0], 1'b0};
            end
        end
    end

    assign bus.Q    = r_Q;
    assign bus.R    = r_R;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dz   = r_dz;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_alu_div.sv
// Scoreboard bench for alu_div: directed operands with hand-computed results,
// latency, handshake, reset-abort and back-to-back throughput checks.
module tb_alu_div;
    logic clk;
    logic ar;

    alu_div_if bus ();

    alu_div dut (
        .clk (clk),
        .ar  (ar),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ovf;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (ar && bus.done) begin
            chk("done_busy_exclusive", {31'd0, bus.busy}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_Q"},   {24'd0, bus.Q},   {24'd0, e.q});
                chk({e.nm, "_R"},   {28'd0, bus.R},   {28'd0, e.r});
                chk({e.nm, "_dz"},  {31'd0, bus.dz},  {31'd0, e.dz});
                chk({e.nm, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e.ovf});
            end
        end
    end

    task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                          input logic [7:0] eq, input logic [3:0] er,
                          input logic edz, input logic eovf,
                          input bit poke, input string nm);
        int lat;
        sb.push_back('{eq, er, edz, eovf, nm});
        @(negedge clk);
        bus.N = n; bus.D = d; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.N = ~n; bus.D = 4'h3;
        chk({nm, "_busy_after_start"}, {31'd0, bus.busy}, {31'd0, (d != 4'h0)});
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (poke) begin
                bus.start = (lat == 3);
                bus.N = 8'hFF; bus.D = 4'h1;
            end
        end while (!bus.done && lat < 20);
        bus.start = 1'b0;
        chk({nm, "_latency"}, lat, (d == 4'h0) ? 32'd1 : 32'd9);
        chk({nm, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_Q"},    {24'd0, bus.Q},    32'd0);
        chk({nm, "_R"},    {28'd0, bus.R},    32'd0);
        chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({nm, "_dz"},   {31'd0, bus.dz},   32'd0);
        chk({nm, "_ovf"},  {31'd0, bus.ovf},  32'd0);
    endtask

    initial begin
        int dpos[$];
        ar = 1'b0;
        bus.start = 1'b0;
        bus.N = 8'h00;
        bus.D = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        ar = 1'b1;

        run_op(8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0, 1'b0, "p100_p7");
        run_op(8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0, 1'b0, 1'b0, "m100_p7");
        run_op(8'h64, 4'h9, 8'hF2, 4'h2, 1'b0, 1'b0, 1'b0, "p100_m7");
        run_op(8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0, 1'b0, 1'b0, "m100_m7");
        run_op(8'h80, 4'h8, 8'h10, 4'h0, 1'b0, 1'b0, 1'b0, "m128_m8");
        run_op(8'h80, 4'h1, 8'h80, 4'h0, 1'b0, 1'b0, 1'b0, "m128_p1");
        run_op(8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 1'b0, "m128_m1");
        run_op(8'h07, 4'h8, 8'h00, 4'h7, 1'b0, 1'b0, 1'b0, "p7_m8");
        run_op(8'h05, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, "p5_div0");
        run_op(8'h09, 4'h3, 8'h03, 4'h0, 1'b0, 1'b0, 1'b0, "p9_p3");
        run_op(8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0, 1'b0, 1'b1, "poke_m100_m7");

        // Reset asserted at edge t+4 of an operation aborts it with no result.
        @(negedge clk);
        bus.N = 8'h64; bus.D = 4'h7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ar = 1'b0;
        @(posedge clk); #1;
        chk_zero("mid_reset");
        @(negedge clk);
        ar = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_reset_no_done", {31'd0, bus.done}, 32'd0);
        run_op(8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0, 1'b0, "after_reset");

        // Continuous start: one result every 10 cycles.
        repeat (3) sb.push_back('{8'h0E, 4'h2, 1'b0, 1'b0, "stream"});
        @(negedge clk);
        bus.N = 8'h64; bus.D = 4'h7; bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 29; k++) begin
            @(posedge clk); #1;
            if (bus.done) dpos.push_back(k);
            if (k == 25) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        chk("stream_done_count", dpos.size(), 32'd3);
        if (dpos.size() == 3) begin
            chk("stream_done0", dpos[0], 32'd9);
            chk("stream_done1", dpos[1], 32'd19);
            chk("stream_done2", dpos[2], 32'd29);
        end

        repeat (12) @(posedge clk);
        #1;
        chk("stream_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
